sharp_lcd_rx: RTL and testbench
===============================

Name: sharp_lcd_rx

Overview:
- Receiver/decoder for the LS013B7DH01 memory-LCD serial protocol (SCS active-high, SCK, SI), i.e. the panel-side end of the link the display driver produces.
- Oversamples the serial lines in the 12 MHz domain and decodes the mode byte, gate-line address, pixel data and dummy bits.
- Emits one decoded line per transfer, plus mode/VCOM state, clear-all and error events.
- Serves as a synthesizable loopback monitor and as the bench scoreboard front-end for the driver.

Parameters:
- DATA_BITS, 144, pixel bits per line.
- NUM_LINES, 168, highest legal gate-line address (legal range is 1..NUM_LINES).
- SYNC_STAGES, 2, flip-flop synchronizer depth on SCS/SCK/SI (min 2).
- MIN_SETUP_CYC, 36, minimum clk_12mhz cycles from SCS rise to first SCK rise. Used only with SHARP_RX_TIMING_CHK_EN.

Ports:
- clk_12mhz  in  1  system clock.
- rst_n  in  1  reset.
- SCS  in  1  serial chip select, active high.
- SCK  in  1  serial clock; SI sampled on rising edge.
- SI  in  1  serial data.
- mode_update  out  1  M0 of the last mode byte.
- vcom  out  1  M1 of the last mode byte.
- clear_all  out  1  one-cycle pulse: mode byte had M2=1.
- line_valid  out  1  one-cycle pulse: line_addr/line_data valid.
- line_addr  out  8  decoded gate-line address.
- line_data  out  DATA_BITS  pixel bits; bit 0 = first bit received.
- frame_done  out  1  one-cycle pulse on legal SCS deassert.
- proto_err  out  1  one-cycle pulse on protocol violation.

Behaviour:
- Clock/reset: single clock clk_12mhz. rst_n is asynchronous, active-low.
- Reset values: all outputs 0, FSM in IDLE, bit counter 0.
- Synchronization: SCS, SCK and SI pass through identical SYNC_STAGES synchronizers. A rising SCK edge is detected on the synchronized SCK (previous 0, current 1); SI is taken from the same synchronized stage.
- Input timing requirement: SCK high and low times ≥ 2 clk_12mhz cycles.
- FSM states: IDLE, MODE, ADDR, DATA, DUMMY, TRAIL.
- IDLE: on synchronized SCS rise, go to MODE with counter=0. SCK edges while SCS is low are ignored.
- MODE: 8 bits. First bit is M0, second M1, third M2; the remaining bits are ignored. After the 8th bit:
  - Latch mode_update and vcom.
  - If M2=1: pulse clear_all, go to TRAIL.
  - Else if M0=0 (static): go to TRAIL.
  - Else: go to ADDR.
- ADDR: 8 bits, LSB first. Address 0 means the trailing dummy byte: go to TRAIL. Address > NUM_LINES: pulse proto_err, go to TRAIL. Otherwise go to DATA.
- DATA: shift DATA_BITS bits. The cycle after the last bit's edge is detected:
  - line_valid=1, with line_addr/line_data updated in the same cycle.
  - Total latency is SYNC_STAGES+2 cycles from the raw SCK rise.
  - line_addr/line_data hold until the next line_valid.
  - Go to DUMMY.
- DUMMY: 8 bits, values ignored, then go to ADDR (multi-line transfer).
- TRAIL: consume and ignore all bits until SCS falls.
- SCS fall (synchronized) ends the transfer:
  - Legal end: state TRAIL, or state ADDR with 0 bits received and ≥1 line delivered in this transfer. Pulse frame_done.
  - Any other state or partial field: pulse proto_err only. No line_valid is produced for the partial line.
  - In all cases, return to IDLE.
- Simultaneous SCK edge and SCS fall in the same cycle: the SCS fall wins and the edge is discarded.
- SCS re-rise: a new transfer restarts cleanly in MODE.
- Reset asserted mid-transfer: immediate return to reset values. No pulses are emitted on deassertion.
- Pulse exclusivity: at most one of frame_done and proto_err fires per transfer end.

Optional Feature:
- Macro: SHARP_RX_TIMING_CHK_EN.
- Defined:
  - A 16-bit saturating counter runs from SCS rise.
  - If the first SCK rise arrives with counter < MIN_SETUP_CYC: pulse proto_err. Decoding still proceeds normally.
  - Any SCK rise within 2 cycles of the previous SCK rise: pulse proto_err.
- Undefined: no timing checks; the counter and MIN_SETUP_CYC are unused and no logic is generated for them.

Test Plan:
- Single line, 1 MHz SCK: mode 0x01 (M0=1), addr 50, data = 144 ones, dummy 0x00, trailer 0x00, SCS low → one line_valid with line_addr=50 and line_data all ones; mode_update=1, vcom=0; then frame_done, no proto_err.
- Multi-line transfer: mode M0=1/M1=1, then lines 1 (data 0xA5 repeated) and 168 (alternating 1/0), trailer → two line_valid pulses with addr 1 then 168 and correct data; vcom=1; one frame_done.
- Clear-all and static: mode M2=1 → clear_all pulse, then frame_done. Mode 0x00 with 16 dummy bits → no line_valid, frame_done.
- Errors:
  - Addr 200 → proto_err, no line_valid.
  - SCS dropped after 100 data bits → proto_err, no line_valid, no frame_done.
  - Next transfer decodes normally.
- rst_n pulled low mid-DATA, released, then a fresh legal line to addr 7 → outputs 0 while in reset, no spurious pulses, addr 7 line decoded.
- With SHARP_RX_TIMING_CHK_EN: first SCK 10 cycles after SCS rise → proto_err, and the line is still delivered. Same stimulus without the macro → no proto_err.

Source files
------------

// File: rtl/sharp_lcd_rx.sv
// sharp_lcd_rx: panel-side decoder for the LS013B7DH01 memory-LCD serial link (SCS/SCK/SI).
// Define SHARP_RX_TIMING_CHK_EN to add SCS-setup and SCK-spacing violation checks.
`timescale 1ns/1ps
module sharp_lcd_rx #(
  parameter int DATA_BITS     = 144,
  parameter int NUM_LINES     = 168,
  parameter int SYNC_STAGES   = 2,
  parameter int MIN_SETUP_CYC = 36
) (
  input  logic                 clk_12mhz,
  input  logic                 rst_n,
  input  logic                 SCS,
  input  logic                 SCK,
  input  logic                 SI,
  output logic                 mode_update,
  output logic                 vcom,
  output logic                 clear_all,
  output logic                 line_valid,
  output logic [7:0]           line_addr,
  output logic [DATA_BITS-1:0] line_data,
  output logic                 frame_done,
  output logic                 proto_err
);
  localparam int CNT_W = (DATA_BITS > 255) ? $clog2(DATA_BITS + 1) : 8;

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (MIN_SETUP_CYC < 0 || MIN_SETUP_CYC > 65535) begin : g_bad_setup
    $error("MIN_SETUP_CYC must fit the 16-bit setup counter");
  end

  typedef enum logic [2:0] {IDLE, MODE, ADDR, DATA, DUMMY, TRAIL} state_t;

  logic [SYNC_STAGES-1:0] scs_sync, sck_sync, si_sync;
  logic scs_p0, sck_p0, si_p0;
  logic scs_prev_p1, sck_prev_p1, scs_rise_p1, scs_fall_p1, edge_p1, si_p1;

  state_t               state_p2, state_n;
  logic [CNT_W-1:0]     cnt_p2, cnt_n;
  logic [2:0]           mode_sh_p2, mode_sh_n;
  logic [7:0]           addr_sh_p2, addr_sh_n, addr_full;
  logic [DATA_BITS-1:0] data_sh_p2, data_sh_n;
  logic                 got_line_p2, got_line_n;
  logic                 mode_update_n, vcom_n, clear_all_n, line_valid_n, frame_done_n, proto_err_n;
  logic [7:0]           line_addr_n;
  logic [DATA_BITS-1:0] line_data_n;
  logic                 tchk_err;

  // p0: metastability synchronizers
  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      scs_sync <= '0;
      sck_sync <= '0;
      si_sync  <= '0;
    end else begin
      scs_sync <= {scs_sync[SYNC_STAGES-2:0], SCS};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], SCK};
      si_sync  <= {si_sync[SYNC_STAGES-2:0], SI};
    end
  end

  assign scs_p0 = scs_sync[SYNC_STAGES-1];
  assign sck_p0 = sck_sync[SYNC_STAGES-1];
  assign si_p0  = si_sync[SYNC_STAGES-1];

  // p1: registered edge events, SI captured alongside the SCK rise
  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      scs_prev_p1 <= 1'b0;
      sck_prev_p1 <= 1'b0;
      scs_rise_p1 <= 1'b0;
      scs_fall_p1 <= 1'b0;
      edge_p1     <= 1'b0;
      si_p1       <= 1'b0;
    end else begin
      scs_prev_p1 <= scs_p0;
      sck_prev_p1 <= sck_p0;
      scs_rise_p1 <= scs_p0 & ~scs_prev_p1;
      scs_fall_p1 <= ~scs_p0 & scs_prev_p1;
      edge_p1     <= sck_p0 & ~sck_prev_p1;
      si_p1       <= si_p0;
    end
  end

  // p2: protocol FSM; an SCS fall in the same cycle as an SCK edge takes priority
  always_comb begin
    state_n       = state_p2;
    cnt_n         = cnt_p2;
    mode_sh_n     = mode_sh_p2;
    addr_sh_n     = addr_sh_p2;
    data_sh_n     = data_sh_p2;
    got_line_n    = got_line_p2;
    mode_update_n = mode_update;
    vcom_n        = vcom;
    line_addr_n   = line_addr;
    line_data_n   = line_data;
    clear_all_n   = 1'b0;
    line_valid_n  = 1'b0;
    frame_done_n  = 1'b0;
    proto_err_n   = 1'b0;
    addr_full     = {si_p1, addr_sh_p2[7:1]};
    if (scs_fall_p1) begin
      state_n = IDLE;
      cnt_n   = '0;
      if (state_p2 == TRAIL || (state_p2 == ADDR && cnt_p2 == '0 && got_line_p2))
        frame_done_n = 1'b1;
      else if (state_p2 != IDLE)
        proto_err_n = 1'b1;
    end else if (scs_rise_p1) begin
      state_n    = MODE;
      cnt_n      = '0;
      got_line_n = 1'b0;
    end else if (edge_p1) begin
      case (state_p2)
        MODE: begin
          if (cnt_p2 == CNT_W'(0)) mode_sh_n[0] = si_p1;
          if (cnt_p2 == CNT_W'(1)) mode_sh_n[1] = si_p1;
          if (cnt_p2 == CNT_W'(2)) mode_sh_n[2] = si_p1;
          cnt_n = cnt_p2 + CNT_W'(1);
          if (cnt_p2 == CNT_W'(7)) begin
            cnt_n         = '0;
            mode_update_n = mode_sh_p2[0];
            vcom_n        = mode_sh_p2[1];
            if (mode_sh_p2[2]) begin
              clear_all_n = 1'b1;
              state_n     = TRAIL;
            end else if (!mode_sh_p2[0]) begin
              state_n = TRAIL;
            end else begin
              state_n = ADDR;
            end
          end
        end
        ADDR: begin
          addr_sh_n = addr_full;
          cnt_n     = cnt_p2 + CNT_W'(1);
          if (cnt_p2 == CNT_W'(7)) begin
            cnt_n = '0;
            if (addr_full == 8'd0) begin
              state_n = TRAIL;
            end else if (addr_full > 8'(NUM_LINES)) begin
              proto_err_n = 1'b1;
              state_n     = TRAIL;
            end else begin
              state_n = DATA;
            end
          end
        end
        DATA: begin
          data_sh_n = {si_p1, data_sh_p2[DATA_BITS-1:1]};
          cnt_n     = cnt_p2 + CNT_W'(1);
          if (cnt_p2 == CNT_W'(DATA_BITS - 1)) begin
            cnt_n        = '0;
            line_valid_n = 1'b1;
            line_addr_n  = addr_sh_p2;
            line_data_n  = data_sh_n;
            got_line_n   = 1'b1;
            state_n      = DUMMY;
          end
        end
        DUMMY: begin
          cnt_n = cnt_p2 + CNT_W'(1);
          if (cnt_p2 == CNT_W'(7)) begin
            cnt_n   = '0;
            state_n = ADDR;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SHARP_RX_TIMING_CHK_EN
  logic [15:0] setup_cnt_p2;
  logic [1:0]  gap_cnt_p2;
  logic        first_pend_p2;

  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      setup_cnt_p2  <= '0;
      gap_cnt_p2    <= '0;
      first_pend_p2 <= 1'b0;
    end else begin
      if (scs_rise_p1) begin
        setup_cnt_p2  <= '0;
        first_pend_p2 <= 1'b1;
      end else begin
        if (setup_cnt_p2 != 16'hFFFF) setup_cnt_p2 <= setup_cnt_p2 + 16'd1;
        if (edge_p1 && state_p2 != IDLE) first_pend_p2 <= 1'b0;
      end
      if (edge_p1) gap_cnt_p2 <= '0;
      else if (gap_cnt_p2 != 2'd3) gap_cnt_p2 <= gap_cnt_p2 + 2'd1;
    end
  end

  // gap_cnt_p2 < 2 means this rise is at most two cycles after the previous one
  always_comb begin
    tchk_err = 1'b0;
    if (edge_p1 && !scs_fall_p1 && state_p2 != IDLE) begin
      if (first_pend_p2 && setup_cnt_p2 < 16'(MIN_SETUP_CYC)) tchk_err = 1'b1;
      if (!first_pend_p2 && gap_cnt_p2 < 2'd2) tchk_err = 1'b1;
    end
  end
`else
  assign tchk_err = 1'b0;
`endif

  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_p2    <= IDLE;
      cnt_p2      <= '0;
      mode_sh_p2  <= '0;
      got_line_p2 <= 1'b0;
      mode_update <= 1'b0;
      vcom        <= 1'b0;
      clear_all   <= 1'b0;
      line_valid  <= 1'b0;
      line_addr   <= '0;
      line_data   <= '0;
      frame_done  <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      state_p2    <= state_n;
      cnt_p2      <= cnt_n;
      mode_sh_p2  <= mode_sh_n;
      got_line_p2 <= got_line_n;
      mode_update <= mode_update_n;
      vcom        <= vcom_n;
      clear_all   <= clear_all_n;
      line_valid  <= line_valid_n;
      line_addr   <= line_addr_n;
      line_data   <= line_data_n;
      frame_done  <= frame_done_n;
      proto_err   <= proto_err_n | tchk_err;
    end
  end

  always_ff @(posedge clk_12mhz) begin
    addr_sh_p2 <= addr_sh_n;
    data_sh_p2 <= data_sh_n;
  end

endmodule

// File: tb/tb_sharp_lcd_rx.sv
// tb_sharp_lcd_rx: directed table-driven bench for sharp_lcd_rx, plus multi-line, abort and reset sequences.
`timescale 1ns/1ps
module tb_sharp_lcd_rx;
  localparam int DB = 144;
`ifdef SHARP_RX_TIMING_CHK_EN
  localparam int TCHK = 1;
`else
  localparam int TCHK = 0;
`endif

  logic          clk_12mhz = 1'b0;
  logic          rst_n = 1'b0;
  logic          SCS = 1'b0, SCK = 1'b0, SI = 1'b0;
  logic          mode_update, vcom, clear_all, line_valid, frame_done, proto_err;
  logic [7:0]    line_addr;
  logic [DB-1:0] line_data;

  sharp_lcd_rx #(.DATA_BITS(DB), .NUM_LINES(168), .SYNC_STAGES(2), .MIN_SETUP_CYC(36)) dut (
    .clk_12mhz(clk_12mhz), .rst_n(rst_n), .SCS(SCS), .SCK(SCK), .SI(SI),
    .mode_update(mode_update), .vcom(vcom), .clear_all(clear_all),
    .line_valid(line_valid), .line_addr(line_addr), .line_data(line_data),
    .frame_done(frame_done), .proto_err(proto_err)
  );

  always #5 clk_12mhz = ~clk_12mhz;

  int n_lv = 0, n_fd = 0, n_pe = 0, n_ca = 0;
  logic [7:0]    q_addr[$];
  logic [DB-1:0] q_data[$];

  always @(negedge clk_12mhz) begin
    if (line_valid) begin
      n_lv++;
      q_addr.push_back(line_addr);
      q_data.push_back(line_data);
    end
    if (frame_done) n_fd++;
    if (proto_err)  n_pe++;
    if (clear_all)  n_ca++;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_12mhz);
  endtask

  // one bit per 12 clocks: SCK low 6, high 6
  task automatic send_bit(input logic b);
    SI = b;
    wait_cyc(3);
    SCK = 1'b1;
    wait_cyc(6);
    SCK = 1'b0;
    wait_cyc(3);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic send_line(input logic [7:0] addr, input logic [DB-1:0] data);
    send_byte(addr);
    for (int i = 0; i < DB; i++) send_bit(data[i]);
    send_byte(8'h00);
  endtask

  task automatic scs_up(input int setup);
    SCS = 1'b1;
    wait_cyc(setup);
  endtask

  task automatic scs_down();
    SCS = 1'b0;
    wait_cyc(16);
  endtask

  typedef struct {
    string         name;
    logic [7:0]    mode;
    bit            has_line;
    logic [7:0]    addr;
    logic [DB-1:0] data;
    int            ntrail;
    int            setup;
    int            exp_lv;
    int            exp_fd;
    int            exp_pe;
    int            exp_ca;
    logic          exp_mu;
    logic          exp_vc;
  } vec_t;

  vec_t vecs[7];

  logic [DB-1:0] ones, pat_a5, pat_alt;

  task automatic run_vec(input vec_t v);
    int lv0, fd0, pe0, ca0;
    lv0 = n_lv; fd0 = n_fd; pe0 = n_pe; ca0 = n_ca;
    scs_up(v.setup);
    send_byte(v.mode);
    if (v.has_line) send_line(v.addr, v.data);
    for (int i = 0; i < v.ntrail; i++) send_byte(8'h00);
    scs_down();
    check({v.name, " line_valid count"}, 160'(n_lv - lv0), 160'(v.exp_lv));
    check({v.name, " frame_done count"}, 160'(n_fd - fd0), 160'(v.exp_fd));
    check({v.name, " proto_err count"}, 160'(n_pe - pe0), 160'(v.exp_pe));
    check({v.name, " clear_all count"}, 160'(n_ca - ca0), 160'(v.exp_ca));
    check({v.name, " mode_update"}, 160'(mode_update), 160'(v.exp_mu));
    check({v.name, " vcom"}, 160'(vcom), 160'(v.exp_vc));
    if (v.exp_lv == 1 && n_lv == lv0 + 1) begin
      check({v.name, " line_addr"}, 160'(q_addr[lv0]), 160'(v.addr));
      check({v.name, " line_data"}, 160'(q_data[lv0]), 160'(v.data));
    end
  endtask

  initial begin
    int lv0, fd0, pe0, ca0;
    ones    = '1;
    pat_a5  = {18{8'hA5}};
    pat_alt = {72{2'b01}};

    vecs[0] = '{"single", 8'h01, 1'b1, 8'd50,  ones,    1, 45, 1, 1, 0,    0, 1'b1, 1'b0};
    vecs[1] = '{"vcom",   8'h03, 1'b1, 8'd1,   pat_a5,  1, 45, 1, 1, 0,    0, 1'b1, 1'b1};
    vecs[2] = '{"clear",  8'h04, 1'b0, 8'd0,   '0,      1, 45, 0, 1, 0,    1, 1'b0, 1'b0};
    vecs[3] = '{"static", 8'h00, 1'b0, 8'd0,   '0,      2, 45, 0, 1, 0,    0, 1'b0, 1'b0};
    vecs[4] = '{"badaddr",8'h01, 1'b1, 8'd200, ones,    1, 45, 0, 1, 1,    0, 1'b1, 1'b0};
    vecs[5] = '{"last",   8'h01, 1'b1, 8'd168, pat_alt, 1, 45, 1, 1, 0,    0, 1'b1, 1'b0};
    vecs[6] = '{"setup",  8'h01, 1'b1, 8'd33,  pat_a5,  1, 7,  1, 1, TCHK, 0, 1'b1, 1'b0};

    wait_cyc(4);
    check("reset mode_update", 160'(mode_update), 160'(0));
    check("reset vcom",        160'(vcom),        160'(0));
    check("reset line_addr",   160'(line_addr),   160'(0));
    check("reset line_data",   160'(line_data),   160'(0));
    check("reset pulses",      160'({clear_all, line_valid, frame_done, proto_err}), 160'(0));
    rst_n = 1'b1;
    wait_cyc(8);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // two lines in one transfer
    lv0 = n_lv; fd0 = n_fd; pe0 = n_pe;
    scs_up(45);
    send_byte(8'h03);
    send_line(8'd1, pat_a5);
    send_line(8'd168, pat_alt);
    send_byte(8'h00);
    scs_down();
    check("multi line_valid count", 160'(n_lv - lv0), 160'(2));
    check("multi frame_done count", 160'(n_fd - fd0), 160'(1));
    check("multi proto_err count",  160'(n_pe - pe0), 160'(0));
    check("multi vcom",             160'(vcom),       160'(1));
    if (n_lv == lv0 + 2) begin
      check("multi addr0", 160'(q_addr[lv0]),     160'(1));
      check("multi data0", 160'(q_data[lv0]),     160'(pat_a5));
      check("multi addr1", 160'(q_addr[lv0 + 1]), 160'(168));
      check("multi data1", 160'(q_data[lv0 + 1]), 160'(pat_alt));
    end

    // SCS dropped after 100 data bits
    lv0 = n_lv; fd0 = n_fd; pe0 = n_pe;
    scs_up(45);
    send_byte(8'h01);
    send_byte(8'd9);
    for (int i = 0; i < 100; i++) send_bit(1'b1);
    scs_down();
    check("abort line_valid count", 160'(n_lv - lv0), 160'(0));
    check("abort frame_done count", 160'(n_fd - fd0), 160'(0));
    check("abort proto_err count",  160'(n_pe - pe0), 160'(1));
    run_vec('{"after_abort", 8'h01, 1'b1, 8'd77, pat_a5, 1, 45, 1, 1, 0, 0, 1'b1, 1'b0});

    // reset in the middle of DATA
    lv0 = n_lv; fd0 = n_fd; pe0 = n_pe; ca0 = n_ca;
    scs_up(45);
    send_byte(8'h03);
    send_byte(8'd12);
    for (int i = 0; i < 60; i++) send_bit(1'b1);
    rst_n = 1'b0;
    wait_cyc(2);
    check("midreset mode_update", 160'(mode_update), 160'(0));
    check("midreset vcom",        160'(vcom),        160'(0));
    check("midreset line_addr",   160'(line_addr),   160'(0));
    check("midreset line_data",   160'(line_data),   160'(0));
    SCS = 1'b0;
    SCK = 1'b0;
    wait_cyc(10);
    rst_n = 1'b1;
    wait_cyc(20);
    check("midreset pulse count", 160'((n_lv - lv0) + (n_fd - fd0) + (n_pe - pe0) + (n_ca - ca0)), 160'(0));
    run_vec('{"after_reset", 8'h01, 1'b1, 8'd7, ones, 1, 45, 1, 1, 0, 0, 1'b1, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
